instr_fetch_ctrl: RTL
=====================

# instr_fetch_ctrl

Fetch-and-sequence controller sitting directly downstream of the program counter, with a feedback path into it. Reads the current PC value, fetches the instruction word over a req/ack memory port, and holds it in an instruction register offered to the decode stage with a valid/ready handshake. Classifies each accepted instruction and drives the PC's 2-bit control and load-value inputs for exactly one cycle.

## Interface
- `AW`, 4: address width. Equals the PC width.
- `DW`, 8: instruction width. Must satisfy `DW >= AW+2`.
- `clk` in 1: clock, rising edge.
- `clr` in 1: asynchronous, active-low reset. The same net also resets the PC.
- `pc_in` in AW: current PC value, from the PC output.
- `pc_ctrl` out 2: PC command.
  - 0 = hold
  - 1 = add `pc_ld`
  - 2 = increment
  - 3 = load `pc_ld`
- `pc_ld` out AW: offset or target value presented to the PC.
- `mem_req` out 1: instruction read request.
- `mem_addr` out AW: read address. Wired directly to `pc_in`.
- `mem_ack` in 1: read data valid on `mem_data`. Ignored unless `mem_req`=1.
- `mem_data` in DW: instruction word.
- `ir` out DW: instruction register.
- `ir_valid` out 1: `ir` holds an instruction not yet accepted by decode.
- `ir_ready` in 1: decode accepts `ir`.
- `cond` in 1: branch condition flag.
- `run` in 1: leave the halted state.
- `halted` out 1: controller is stopped.

## Operation
- Opclass is `ir[DW-1:DW-2]`. Field F is `ir[AW-1:0]`.
  - 00 = sequential
  - 01 = conditional relative branch by F
  - 10 = absolute jump to F
  - 11 = halt
- FSM states: HALT, FETCH, ISSUE, UPDATE. All outputs are Moore, taken from registers or state decode.
- HALT
  - `halted`=1.
  - `run`=1 → go to FETCH. Otherwise stay.
- FETCH
  - `mem_req`=1.
  - At a clock edge with `mem_ack`=1: `ir`<=`mem_data`, then go to ISSUE.
  - Otherwise stay, with `mem_req` held high.
- ISSUE
  - `ir_valid`=1.
  - At a clock edge with `ir_ready`=1, `pc_ctrl`/`pc_ld` are registered from `ir` and `cond` (sampled at that edge), then go to UPDATE:
    - 00 → `pc_ctrl`=2.
    - 01 with `cond`=1 → `pc_ctrl`=1, `pc_ld`=F.
    - 01 with `cond`=0 → `pc_ctrl`=2.
    - 10 → `pc_ctrl`=3, `pc_ld`=F.
    - 11 → `pc_ctrl`=0.
  - `ir` is stable while `ir_valid`=1.
- UPDATE
  - `pc_ctrl` holds the value registered in ISSUE for exactly this cycle. The PC applies it at the end of the cycle.
  - Next state: HALT if opclass 11, otherwise FETCH.
  - `pc_ctrl` returns to 0 on leaving UPDATE.
- `pc_ctrl` is 0 in every state other than UPDATE. The PC therefore never changes during FETCH, and `mem_addr` is stable for the whole request.
- Arithmetic:
  - The relative add is performed by the PC, mod 2^AW.
  - A backward branch is encoded as a two's-complement F: F=0xF at AW=4 means −1.
  - Address wrap (0xF+1→0x0) is legal and silent.
- `pc_ld` holds its last value outside UPDATE. Its reset value is 0.
- Simultaneous events:
  - `mem_ack` together with `ir_ready` in FETCH: `ir_ready` is irrelevant, since `ir_valid`=0.
  - `run` outside HALT: ignored.
  - `cond` outside the ISSUE handshake edge: ignored.

## Timing
- Reset (`clr`=0) takes effect immediately, without waiting for a clock edge:
  - state = HALT
  - `halted`=1
  - `mem_req`=0, `ir_valid`=0
  - `ir`=0
  - `pc_ctrl`=0, `pc_ld`=0
- Reset mid-fetch or mid-issue drops the transaction. There is no partial PC update: `pc_ctrl` is forced to 0 asynchronously.
- Release of `clr` is synchronous to `clk` by the SoC reset synchroniser. The first edge after release stays in HALT unless `run`=1.
- Minimum instruction period is 3 cycles: FETCH (with `ack` in the first cycle), ISSUE (with `ready` in the first cycle), UPDATE.
- Extra cycles add one for one:
  - Each cycle `mem_ack` is late adds one FETCH cycle.
  - Each cycle `ir_ready` is low adds one ISSUE cycle.
- `ir` is loaded at the FETCH→ISSUE edge and is visible in the first ISSUE cycle.
- The new `pc_in` is visible in the first FETCH cycle after UPDATE.
- A halt instruction costs ISSUE + UPDATE. `halted` rises in the cycle after UPDATE.
- `run`=1 in HALT → `mem_req`=1 on the next cycle, with `mem_addr` = the unchanged PC.

## Test plan
- **Sequential fetch.** Reset, pulse `run`, PC=0, memory returns 0x00 with immediate ack, `ir_ready`=1.
  - `ir`=0x00 and `ir_valid` for 1 cycle.
  - `pc_ctrl`=2 for exactly 1 cycle.
  - The next request has `mem_addr`=1, arriving 3 cycles after the previous request.
- **Conditional branch.** `ir`=0x43 at PC=5.
  - `cond`=1 → `pc_ctrl`=1, `pc_ld`=3, next `mem_addr`=8.
  - `cond`=0 → `pc_ctrl`=2, next `mem_addr`=6.
- **Jump and wrap.**
  - `ir`=0x8C at PC=2 → `pc_ctrl`=3, `pc_ld`=0xC, next address 12.
  - `ir`=0x4F with `cond`=1 at PC=0xE → next address 0xD.
- **Halt and restart.** `ir`=0xC0 → `pc_ctrl` stays 0, `halted`=1, `mem_req`=0 for 10 cycles while `run`=0. Then `run`=1 → FETCH at the same PC.
- **Backpressure.** `mem_ack` is 3 cycles late and `ir_ready` is low for 2 cycles.
  - `mem_req` is held for 4 cycles with a stable `mem_addr`.
  - `ir` stays stable while valid.
  - `pc_ctrl`=0 until the handshake.
  - Total instruction period is 8 cycles.
- **Asynchronous reset.** Assert `clr` between clock edges during FETCH and again during UPDATE. All outputs reach their reset values before the next edge, and `pc_ctrl`=0 at that edge, so the PC is not advanced.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// Memory read port and decode handshake of the fetch controller.
// The controller uses the master modport; memory and decode sit on the slave side.
interface instr_fetch_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] ir;
  logic          ir_valid;
  logic          ir_ready;

  modport master (
    output mem_req, mem_addr, ir, ir_valid,
    input  mem_ack, mem_data, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir, ir_valid,
    output mem_ack, mem_data, ir_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch-and-sequence controller: fetches at pc_in, offers the word to decode,
// then steers the PC for exactly one cycle. DW must be at least AW+2.
module instr_fetch_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [AW-1:0]       pc_in,
  output logic [1:0]          pc_ctrl,
  output logic [AW-1:0]       pc_ld,
  instr_fetch_ctrl_if.master  bus,
  input  logic                cond,
  input  logic                run,
  output logic                halted,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] S_HALT   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  localparam logic [1:0] PC_HOLD = 2'd0;
  localparam logic [1:0] PC_ADD  = 2'd1;
  localparam logic [1:0] PC_INC  = 2'd2;
  localparam logic [1:0] PC_LOAD = 2'd3;

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_BR   = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [1:0]    pc_ctrl_q, pc_ctrl_d;
  logic [AW-1:0] pc_ld_q, pc_ld_d;
  logic [1:0]    opclass;
  logic [AW-1:0] field;

  assign opclass = ir_q[DW-1:DW-2];
  assign field   = ir_q[AW-1:0];

  // Handshakes: mem_req stays high through FETCH until a cycle with mem_ack;
  // ir_valid stays high through ISSUE until a cycle with ir_ready, and ir is
  // frozen for that whole time. A transfer happens on the edge where both are 1.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_ctrl_d = PC_HOLD;
    pc_ld_d   = pc_ld_q;
    case (state_q)
      S_HALT: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.mem_ack) begin
          ir_d    = bus.mem_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.ir_ready) begin
          state_d = S_UPDATE;
          case (opclass)
            OP_SEQ: pc_ctrl_d = PC_INC;
            OP_BR: begin
              if (cond) begin
                pc_ctrl_d = PC_ADD;
                pc_ld_d   = field;
              end else begin
                pc_ctrl_d = PC_INC;
              end
            end
            OP_JMP: begin
              pc_ctrl_d = PC_LOAD;
              pc_ld_d   = field;
            end
            default: pc_ctrl_d = PC_HOLD;
          endcase
        end
      end
      S_UPDATE: begin
        // pc_ctrl_d defaults to HOLD, so the command lives for this cycle only
        state_d = (opclass == OP_HALT) ? S_HALT : S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_HALT;
      ir_q      <= '0;
      pc_ctrl_q <= PC_HOLD;
      pc_ld_q   <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_ctrl_q <= pc_ctrl_d;
      pc_ld_q   <= pc_ld_d;
    end
  end

  // The PC only moves in UPDATE, so mem_addr is stable across a whole request.
  assign bus.mem_addr = pc_in;
  assign bus.mem_req  = (state_q == S_FETCH);
  assign bus.ir_valid = (state_q == S_ISSUE);
  assign bus.ir       = ir_q;
  assign halted       = (state_q == S_HALT);
  assign pc_ctrl      = pc_ctrl_q;
  assign pc_ld        = pc_ld_q;
  assign state_dbg    = state_q;

endmodule
